// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (master) and the bit-serial adder sequencer (slave).
// Latency: n/a (wires only). Backpressure: none; requester watches busy, starts during busy are dropped.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, output a, output b,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input busy, input done, input sum, input cout
  );

  modport slave (
    input start, input a, input b,
`ifdef SERIAL_ADD_SUB_EN
    input sub,
`endif
    output busy, output done, output sum, output cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused LSB-first over WIDTH cycles; SERIAL_ADD_SUB_EN adds subtract.
// Latency: done pulses WIDTH+1 cycles after the accepted start; start-to-start minimum WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy are ignored, nothing is queued.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_c;
  logic               r_cout;
  logic               r_sub;

  logic               w_sub_in;
  logic               w_accept;
  logic               w_last;
  logic               w_busy;
  logic               w_done;

  logic               w_sb_bit;
  logic               w_ha1_s;
  logic               w_ha1_c;
  logic               w_ha2_c;
  logic               w_s;
  logic               w_carry;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub_in = bus.sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // One full adder built from two half adders and an OR; B is inverted for subtract.
  assign w_sb_bit = r_sb[0] ^ r_sub;
  assign w_ha1_s  = r_sa[0] ^ w_sb_bit;
  assign w_ha1_c  = r_sa[0] & w_sb_bit;
  assign w_s      = w_ha1_s ^ r_c;
  assign w_ha2_c  = w_ha1_s & r_c;
  assign w_carry  = w_ha1_c | w_ha2_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: w_accept = bus.start;
      S_RUN: begin
        w_busy = 1'b1;
        w_last = (r_cnt == LAST);
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_sub  <= 1'b0;
    end else if (w_accept) begin
      r_sa   <= bus.a;
      r_sb   <= bus.b;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_c    <= w_sub_in;
      r_sub  <= w_sub_in;
    end else if (r_state == S_RUN) begin
      r_sa   <= r_sa >> 1;
      r_sb   <= r_sb >> 1;
      r_sum  <= {w_s, r_sum[WIDTH-1:1]};
      r_cnt  <= r_cnt + CNT_W'(1);
      r_c    <= w_carry;
      // cout is only published with the final bit so it stays stable until the next result.
      if (w_last) r_cout <= w_carry;
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and table-driven checks of serial_add_ctrl at WIDTH=8, plus an exhaustive WIDTH=2 sweep.
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_add_ctrl #(.WIDTH(W)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  serial_add_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         sub;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit s,
                        output logic [7:0] rs, output logic rc, output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = s;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    lat = 1;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) bcnt++;
    rs = bus.sum;
    rc = bus.cout;
  endtask

  task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input bit s,
                         output logic [1:0] rs, output logic rc, output int lat);
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.a = a;
    bus2.b = b;
`ifdef SERIAL_ADD_SUB_EN
    bus2.sub = s;
`endif
    @(negedge clk);
    bus2.start = 1'b0;
    lat = 1;
    while (!bus2.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = bus2.sum;
    rc = bus2.cout;
  endtask

  initial begin
    logic [7:0] rs;
    logic [1:0] rs2;
    logic       rc;
    logic [8:0] ex;
    logic [2:0] ex2;
    int         lat;
    int         bcnt;
    int         n;
    int         dcnt;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0};
    tbl[6] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1};
    tbl[7] = '{8'h3C, 8'h3C, 1'b1, 8'h00, 1'b1};
    tbl[8] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
    bus2.sub = 1'b0;
`endif

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_sum",  64'(bus.sum),  64'd0);
    chk("reset_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].sub && !SUB_EN) continue;
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, rs, rc, lat, bcnt);
      chk($sformatf("vec%0d_sum", i),  64'(rs),   64'(tbl[i].es));
      chk($sformatf("vec%0d_cout", i), 64'(rc),   64'(tbl[i].ec));
      chk($sformatf("vec%0d_lat", i),  64'(lat),  64'd9);
      chk($sformatf("vec%0d_busy", i), 64'(bcnt), 64'd9);
      @(negedge clk);
      chk($sformatf("vec%0d_idle_done", i), 64'(bus.done), 64'd0);
      chk($sformatf("vec%0d_idle_busy", i), 64'(bus.busy), 64'd0);
      chk($sformatf("vec%0d_hold_sum", i),  64'(bus.sum),  64'(tbl[i].es));
    end

    // start held high: back-to-back, with operands changed after the first acceptance
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h01;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    @(negedge clk);
    bus.a = 8'hA5; bus.b = 8'h5A;
    n = 1;
    while (!bus.done && n < 40) begin @(negedge clk); n++; end
    chk("b2b_first_lat",  64'(n), 64'd9);
    chk("b2b_first_sum",  64'(bus.sum),  64'h00);
    chk("b2b_first_cout", 64'(bus.cout), 64'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 40);
    bus.start = 1'b0;
    chk("b2b_interval",    64'(n), 64'd10);
    chk("b2b_second_sum",  64'(bus.sum),  64'hFF);
    chk("b2b_second_cout", 64'(bus.cout), 64'd0);
    repeat (3) @(negedge clk);
    chk("b2b_no_retrigger", 64'(bus.busy), 64'd0);

    // start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h04;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    dcnt = 0;
    rs = 8'hXX;
    for (int k = 0; k < 25; k++) begin
      if (bus.done) begin dcnt++; rs = bus.sum; end
      @(negedge clk);
    end
    chk("busy_start_done_count", 64'(dcnt), 64'd1);
    chk("busy_start_sum",        64'(rs),   64'h07);

    // get cout=1 on record, then reset mid-RUN
    run_op(8'hFF, 8'hFF, 1'b0, rs, rc, lat, bcnt);
    chk("pre_reset_cout", 64'(rc), 64'd1);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    chk("midrun_rst_busy", 64'(bus.busy), 64'd0);
    chk("midrun_rst_done", 64'(bus.done), 64'd0);
    chk("midrun_rst_sum",  64'(bus.sum),  64'd0);
    chk("midrun_rst_cout", 64'(bus.cout), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.done || bus.busy) dcnt++;
      @(negedge clk);
    end
    chk("midrun_rst_no_activity", 64'(dcnt), 64'd0);

    // exhaustive WIDTH=2 sweep (counter is a single bit here)
    for (int s = 0; s < 2; s++) begin
      if (s == 1 && !SUB_EN) continue;
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          run_op2(2'(x), 2'(y), s[0], rs2, rc, lat);
          if (s == 1) ex2 = {(x >= y), 2'(x - y)};
          else        ex2 = 3'(x + y);
          chk($sformatf("w2_%0d_%0d_%0d", s, x, y), 64'({rc, rs2}), 64'(ex2));
          chk($sformatf("w2_%0d_%0d_%0d_lat", s, x, y), 64'(lat), 64'd3);
        end
      end
    end

    // random regression at WIDTH=8
    for (int k = 0; k < 300; k++) begin
      logic [7:0] ra, rb;
      bit         rsub;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rsub = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(ra, rb, rsub, rs, rc, lat, bcnt);
      if (rsub) ex = {(ra >= rb), ra - rb};
      else      ex = {1'b0, ra} + {1'b0, rb};
      chk($sformatf("rand%0d_%0h_%0h_%0d", k, ra, rb, rsub), 64'({rc, rs}), 64'(ex));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. It time-shares a single one-bit full-adder datapath (two half adders plus a carry OR) to add two WIDTH-bit operands, one bit per cycle, LSB first. It sits between a requester using a start/done handshake and the one-bit adder cell, and owns operand shifting, carry storage, bit counting and result assembly.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start
- b  input  WIDTH  operand B; captured on the accepted start
- sub  input  1  subtract select; captured on the accepted start; present only with SERIAL_ADD_SUB_EN
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result register
- cout  output  1  final carry out of bit WIDTH-1

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - latch a into shift register SA and b into SB;
  - clear the sum shift register;
  - carry register c = 0 (or c = sub with the macro);
  - bit counter cnt = 0.
- RUN, each cycle:
  - bit sum s = SA[0]^SB'[0]^c, where SB' = SB, or SB^{WIDTH{sub}} with the macro;
  - next carry c = (SA[0]&SB'[0]) | (c&(SA[0]^SB'[0])), formed as two half adders plus an OR;
  - SA and SB shift right by one;
  - sum shift register shifts right with s inserted at the MSB;
  - cnt increments.
- RUN -> DONE when cnt reaches WIDTH-1 and that bit has been processed, so exactly WIDTH RUN cycles.
- DONE: done=1 and cout = final c. Always returns to IDLE on the next cycle.
- Result arithmetic: sum = (A+B) mod 2^WIDTH and cout = bit WIDTH of A+B. With sub=1, sum = (A-B) mod 2^WIDTH and cout = 1 iff A >= B (unsigned, no borrow).
- start while busy=1 is ignored. No queuing, and the in-flight operands are not disturbed.
- a, b and sub may change freely after the accepted start.
- sum and cout hold their values from DONE until the next accepted start, which clears sum to 0.
- Counter width is $clog2(WIDTH). Counter wrap is never reached because the FSM exits RUN first.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE; busy=0, done=0, sum=0, cout=0; all internal registers 0.
- Reset mid-RUN or mid-DONE aborts the operation. Reset dominates start in the same cycle.
- Start accepted at edge T0 (start=1 in IDLE):
  - busy=1 from T0+1;
  - RUN occupies edges T0+1..T0+WIDTH;
  - DONE is visible in cycle T0+WIDTH+1 with done=1 and sum/cout valid;
  - busy=0 from T0+WIDTH+2.
- Latency from start to done is WIDTH+1 cycles. The minimum start-to-start interval is WIDTH+2 cycles.
- start held high continuously re-triggers in the first IDLE cycle after DONE.
- done is high for exactly one cycle per accepted start and never high while in IDLE.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - sub port exists;
  - the captured sub inverts the B bits and seeds the carry with 1, giving two's-complement subtraction.
- SERIAL_ADD_SUB_EN undefined:
  - no sub port;
  - carry seed is 0 and B is never inverted (add only);
  - logic is otherwise identical, including timing.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, start pulse -> done exactly 9 cycles later with sum=8'h10, cout=0; busy high for 9 cycles.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0. Back-to-back with start held high: second done 10 cycles after the first.
- Start accepted with a=8'h03, b=8'h04; pulse start again with a=8'hFF, b=8'hFF at cycle 3 -> second start ignored; result sum=8'h07, single done pulse.
- Start accepted with a=8'h80, b=8'h80; rst_n=0 for one cycle at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
- With SERIAL_ADD_SUB_EN, sub=1:
  - a=8'h05, b=8'h07 -> sum=8'hFE, cout=0;
  - a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
- Random regression over 1000 operand pairs for WIDTH=2, 8 and 32, compared against {cout,sum} = a+b, and against a-b when the macro is defined.
